// File: rtl/cpu_out_uart_tx_pkg.sv
// cpu_io_pkg: shared FSM states, status bit indices and frame sizes for cpu_out_uart_tx.
// CPU_OUT_UART_TX_PARITY_EN adds an even-parity bit and sets the capability flag.
package cpu_io_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_e;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR = 2;
  localparam int ST_PAR = 3;
  localparam int DATA_BITS = 8;
`ifdef CPU_OUT_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam logic PAR_EN = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam logic PAR_EN = 1'b0;
`endif
endpackage

// File: rtl/cpu_out_uart_tx_if.sv
// cpu_out_uart_tx_if: CPU write port, status byte and serial line of the UART transmitter.
interface cpu_out_uart_tx_if;
  logic wr_en;
  logic [7:0] wr_data;
  logic [7:0] status;
  logic tx;
  modport master(output wr_en, output wr_data, input status, input tx);
  modport slave(input wr_en, input wr_data, output status, output tx);
endinterface

// File: rtl/cpu_out_uart_tx_baud_tick_gen.sv
// baud_tick_gen: counts 0..CLKS_PER_BIT-1 and ticks on the last cycle of each bit; clr holds it at 0.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = !clr_i && cnt_q == CW'(CLKS_PER_BIT - 1);
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cpu_out_uart_tx.sv
// cpu_out_uart_tx: 8N1 UART transmitter with one holding register; status feeds CPU in2.
// Define CPU_OUT_UART_TX_PARITY_EN for an even-parity bit between data and stop.
module cpu_out_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  cpu_out_uart_tx_if.slave bus
);
  localparam int BW = $clog2(DATA_W);
  state_e state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic full_q, full_d, ovr_q, ovr_d, tx_q, tx_d;
  logic tick, load, accept;
  logic [7:0] st;
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .clr_i(state_q == IDLE),
    .tick_o(tick)
  );
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    load = 1'b0;
    case (state_q)
      IDLE: load = full_q;
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        bit_d = bit_q + 1'b1;
`ifdef CPU_OUT_UART_TX_PARITY_EN
        if (bit_q == BW'(DATA_W - 1)) state_d = PARITY;
`else
        if (bit_q == BW'(DATA_W - 1)) state_d = STOP;
`endif
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        state_d = IDLE;
        load = full_q;
      end
      default: state_d = IDLE;
    endcase
    // a reload from STOP goes straight to START so back-to-back frames have no idle gap
    if (load) state_d = START;
    shift_d = load ? hold_q : shift_q;
    accept = bus.wr_en && (!full_q || load);
    hold_d = accept ? bus.wr_data : hold_q;
    full_d = accept || (full_q && !load);
    ovr_d = ovr_q || (bus.wr_en && !accept);
    tx_d = state_d == START ? 1'b0 :
           state_d == DATA ? shift_d[bit_d] :
           state_d == PARITY ? ^shift_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q <= '0;
      shift_q <= '0;
      bit_q <= '0;
      full_q <= 1'b0;
      ovr_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      full_q <= full_d;
      ovr_q <= ovr_d;
      tx_q <= tx_d;
    end
  end
  always_comb begin
    st = '0;
    st[ST_BUSY] = state_q != IDLE;
    st[ST_FULL] = full_q;
    st[ST_OVR] = ovr_q;
    st[ST_PAR] = PAR_EN;
  end
  assign bus.status = st;
  assign bus.tx = tx_q;
endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// tb_cpu_out_uart_tx: directed and random writes checked every cycle against a frame-position model.
module tb_cpu_out_uart_tx;
  localparam int C = 4;
`ifdef CPU_OUT_UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int FB = 10;
  localparam logic PAR = 1'b0;
`endif
  localparam int FL = FB * C;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  logic m_busy, m_hv, m_ovr;
  int m_k;
  logic [7:0] m_cur, m_hold;
  cpu_out_uart_tx_if bus();
  cpu_out_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic exp_tx();
    int i;
    if (!m_busy) return 1'b1;
    i = m_k / C;
    if (i == 0) return 1'b0;
    if (i <= 8) return m_cur[i-1];
    if (PAR && i == 9) return ^m_cur;
    return 1'b1;
  endfunction
  // line position within the frame decides tx; the hold register and overrun follow the write rules
  task automatic model(input logic w, input logic [7:0] d, input logic r);
    logic fe, ld, acc;
    if (r) begin
      m_busy = 0; m_hv = 0; m_ovr = 0; m_k = 0; m_cur = 0; m_hold = 0;
      return;
    end
    fe = m_busy && m_k == FL - 1;
    ld = m_hv && (!m_busy || fe);
    acc = w && (!m_hv || ld);
    if (ld) begin
      m_cur = m_hold; m_busy = 1; m_k = 0;
    end else if (fe) begin
      m_busy = 0; m_k = 0;
    end else if (m_busy) m_k++;
    if (acc) begin
      m_hold = d; m_hv = 1;
    end else begin
      if (w) m_ovr = 1;
      if (ld) m_hv = 0;
    end
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    chk("tx", {7'b0, bus.tx}, {7'b0, exp_tx()});
    chk("status", bus.status, {4'b0, PAR, m_ovr, m_hv, m_busy});
    bus.wr_en = w;
    bus.wr_data = d;
    reset = r;
    model(w, d, r);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask
  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    model(0, 8'h00, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx", {7'b0, bus.tx}, 8'h01);
    chk("rst_status", bus.status, {4'b0, PAR, 3'b000});
    step(1, 8'hA5, 0);
    idle(FL + 6);
    step(1, 8'h3C, 0);
    step(0, 8'h00, 0);
    step(1, 8'hC3, 0);
    idle(2 * FL + 6);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    idle(2 * FL + 6);
    step(0, 8'h00, 1);
    step(1, 8'h5A, 0);
    idle(15);
    step(0, 8'h00, 1);
    step(1, 8'h01, 0);
    idle(FL + 6);
    step(0, 8'h00, 1);
    step(1, 8'hAA, 0);
    step(0, 8'h00, 0);
    step(1, 8'h55, 0);
    idle(FL - 2);
    step(1, 8'h0F, 0);
    idle(3 * FL + 6);
    step(0, 8'h00, 1);
    step(1, 8'h07, 0);
    idle(FL + 6);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(7) == 0, 8'($urandom), $urandom_range(599) == 0);
    idle(3 * FL);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_out_uart_tx.md
Name: cpu_out_uart_tx

Overview:
- Output-side peripheral for the single-cycle CPU.
- Consumes bytes the CPU writes to an output port and transmits them as 8N1 UART frames, LSB first.
- Provides one holding register so a second write can be queued behind the frame in flight.
- Returns a status byte that is wired to a CPU input port (in2), so software can poll busy, full and overrun.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per UART bit; legal range ≥2; default kept small for simulation.
- DATA_W, 8, data width; fixed at 8, matches the CPU port width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- wr_en  in  1  one-cycle write strobe from the CPU output-port decode.
- wr_data  in  8  byte written by the CPU (out port value).
- status  out  8  to CPU in port:
  - [0] busy (FSM not IDLE)
  - [1] hold_full
  - [2] overrun (sticky)
  - [7:3] = 0
- tx  out  1  serial line; idles high.

Behaviour:
- Interface is decided: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - tx=1, status=8'h00.
  - FSM=IDLE, hold empty, bit/baud counters=0, overrun=0.
- Reset asserted mid-frame aborts the frame; tx=1 after that edge; queued byte discarded.
- All outputs are registered.
- Write acceptance:
  - wr_en at an edge with hold empty → wr_data captured into hold; hold_full=1.
  - wr_en with hold full → byte dropped; overrun=1 (sticky until reset).
  - Simultaneous case: wr_en on the same edge that hold transfers to the shifter → write accepted; hold stays full with the new byte; no overrun.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If hold full at an edge: load shifter from hold, clear hold, go to START, tx=0 from that edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
- DATA:
  - tx=shifter[bit_idx] for CLKS_PER_BIT cycles per bit.
  - After bit_idx=7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - Then if hold full: load shifter and go directly to START, with no idle gap.
  - Else go to IDLE.
- Latency: write captured at edge E0 while idle → tx falls at edge E1.
- Frame length: 10*CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is held at 0 in IDLE.
- busy=1 from the START entry edge through the last STOP cycle.
- wr_en asserted for N consecutive cycles is N separate writes; software must pulse.

Optional Feature:
- Macro: CPU_OUT_UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles.
  - status[3]=1 as a capability flag.
- Undefined:
  - No PARITY state; 10-bit frame; status[3]=0.

Decomposition:
- Package cpu_io_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, PARITY).
  - Status bit index constants (ST_BUSY=0, ST_FULL=1, ST_OVR=2, ST_PAR=3).
  - Frame bit counts.
- One sub-module, baud_tick_gen:
  - Parameterised CLKS_PER_BIT counter with synchronous clear input.
  - Emits a one-cycle tick on the last cycle of each bit.

Test Plan:
- CLKS_PER_BIT=4, write 8'hA5 while idle:
  - tx low from next edge.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - status[0]=1 during the frame, 0 after 40 cycles.
- Write 8'h3C, then 8'hC3 two cycles later:
  - hold_full=1.
  - Second frame starts immediately after the first STOP, with no idle cycle.
  - Total 80 cycles.
- Write three bytes back-to-back in 3 consecutive cycles:
  - Bytes 1 and 2 are transmitted.
  - Byte 3 is dropped; status=8'h07 during frame 1.
  - overrun stays 1 after both frames finish.
- Reset asserted for one cycle at cycle 15 of a frame:
  - tx=1 and status=8'h00 after that edge.
  - Subsequent write 8'h01 transmits correctly.
- Write timed to the exact edge the STOP→START reload occurs:
  - Byte accepted into hold; no overrun.
  - Three frames transmitted in order.
- With CPU_OUT_UART_TX_PARITY_EN, write 8'hA5:
  - Parity bit 0 after data; frame 44 cycles.
  - Write 8'h07: parity bit 1.
  - status[3]=1.
